// File: rtl/monobit_block_engine.sv
// rtl/monobit_block_engine.sv - blocked NIST monobit sum and runs tester
// Splits a multi-lane bitstream into 2^LOG2_BLOCK-bit blocks; reports S, runs, pass and tallies.
module monobit_block_engine #(
  parameter int LANES      = 4,
  parameter int LOG2_BLOCK = 10,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  cont,
  input  logic [LOG2_BLOCK:0]   threshold,
  input  logic [LANES-1:0]      bits_in,
  input  logic                  bits_valid,
  output logic                  in_ready,
  output logic                  result_valid,
  output logic [LOG2_BLOCK+1:0] sum_out,
  output logic [LOG2_BLOCK:0]   runs_out,
  output logic                  pass,
  output logic                  busy,
  output logic [CNT_W-1:0]      blocks_done,
  output logic [CNT_W-1:0]      blocks_failed
);
  localparam int W     = LOG2_BLOCK + 1;
  localparam int S_W   = LOG2_BLOCK + 2;
  localparam int BEATS = (1 << LOG2_BLOCK) / LANES;
  localparam int BC_W  = $clog2(BEATS);
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);
  localparam logic [S_W-1:0]  BLOCK_S   = {2'b01, {LOG2_BLOCK{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;
  state_t state, state_nxt;

  logic [W-1:0]    thr_q;
  logic            cont_q;
  logic [W-1:0]    ones_q, trans_q, ones_nxt, trans_nxt;
  logic [BC_W-1:0] beat_cnt;
  logic            last_bit_q;
  logic [S_W-1:0]  sum_nxt, abs_nxt;
  logic            pass_nxt;
  logic            start_go, accept, final_beat;

  assign start_go   = (state == IDLE) && ena && start && !stop;
  assign accept     = (state == ACCUM) && ena && bits_valid && !stop;
  assign final_beat = accept && (beat_cnt == LAST_BEAT);
  assign in_ready   = (state == ACCUM);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_go) state_nxt = ACCUM;
      end
      ACCUM: begin
        if (ena && stop)     state_nxt = IDLE;
        else if (final_beat) state_nxt = REPORT;
      end
      REPORT: begin
        if (ena) state_nxt = (cont_q && !stop) ? ACCUM : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lane 0 is earliest, so the cross-beat pair is previous lane LANES-1 against current lane 0.
  always_comb begin
    ones_nxt  = ones_q;
    trans_nxt = trans_q;
    for (int i = 0; i < LANES; i++) ones_nxt = ones_nxt + W'(bits_in[i]);
    for (int i = 1; i < LANES; i++) trans_nxt = trans_nxt + W'(bits_in[i] ^ bits_in[i-1]);
    if (beat_cnt != '0) trans_nxt = trans_nxt + W'(last_bit_q ^ bits_in[0]);
    sum_nxt  = {ones_nxt, 1'b0} - BLOCK_S;
    abs_nxt  = sum_nxt[S_W-1] ? -sum_nxt : sum_nxt;
    pass_nxt = (abs_nxt <= {1'b0, thr_q});
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      thr_q         <= '0;
      cont_q        <= 1'b0;
      ones_q        <= '0;
      trans_q       <= '0;
      beat_cnt      <= '0;
      last_bit_q    <= 1'b0;
      result_valid  <= 1'b0;
      sum_out       <= '0;
      runs_out      <= '0;
      pass          <= 1'b0;
      blocks_done   <= '0;
      blocks_failed <= '0;
    end else begin
      result_valid <= 1'b0;
      if (start_go) begin
        thr_q         <= threshold;
        cont_q        <= cont;
        ones_q        <= '0;
        trans_q       <= '0;
        beat_cnt      <= '0;
        blocks_done   <= '0;
        blocks_failed <= '0;
      end else if (accept) begin
        last_bit_q <= bits_in[LANES-1];
        if (final_beat) begin
          ones_q       <= '0;
          trans_q      <= '0;
          beat_cnt     <= '0;
          result_valid <= 1'b1;
          sum_out      <= sum_nxt;
          runs_out     <= trans_nxt + W'(1);
          pass         <= pass_nxt;
          if (blocks_done != '1) blocks_done <= blocks_done + CNT_W'(1);
          if (!pass_nxt && blocks_failed != '1) blocks_failed <= blocks_failed + CNT_W'(1);
        end else begin
          ones_q   <= ones_nxt;
          trans_q  <= trans_nxt;
          beat_cnt <= beat_cnt + BC_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_monobit_block_engine.sv
// tb/tb_monobit_block_engine.sv - self-checking bench for monobit_block_engine
module tb_monobit_block_engine;
  logic        clk = 1'b0;
  logic        rst_n, ena, start, stop, cont, bits_valid;
  logic [4:0]  threshold;
  logic [3:0]  bits_in;
  logic        in_ready, result_valid, pass, busy;
  logic [5:0]  sum_out;
  logic [4:0]  runs_out;
  logic [15:0] blocks_done, blocks_failed;
  logic        s_in_ready, s_result_valid, s_pass, s_busy;
  logic [5:0]  s_sum;
  logic [4:0]  s_runs;
  logic [1:0]  s_done, s_failed;

  typedef struct packed {
    logic [15:0] beats;
    logic [4:0]  thr;
    logic [5:0]  sum;
    logic [4:0]  runs;
    logic        pass;
  } vec_t;

  typedef struct packed {
    logic [5:0]  sum;
    logic [4:0]  runs;
    logic        pass;
    logic [15:0] done;
    logic [15:0] failed;
  } exp_t;

  vec_t vecs [10];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  monobit_block_engine #(.LANES(4), .LOG2_BLOCK(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .stop(stop), .cont(cont),
    .threshold(threshold), .bits_in(bits_in), .bits_valid(bits_valid),
    .in_ready(in_ready), .result_valid(result_valid), .sum_out(sum_out),
    .runs_out(runs_out), .pass(pass), .busy(busy),
    .blocks_done(blocks_done), .blocks_failed(blocks_failed)
  );

  monobit_block_engine #(.LANES(4), .LOG2_BLOCK(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .stop(stop), .cont(cont),
    .threshold(threshold), .bits_in(bits_in), .bits_valid(bits_valid),
    .in_ready(s_in_ready), .result_valid(s_result_valid), .sum_out(s_sum),
    .runs_out(s_runs), .pass(s_pass), .busy(s_busy),
    .blocks_done(s_done), .blocks_failed(s_failed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (result_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result sum=%0h runs=%0h t=%0t", sum_out, runs_out, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum_out", 32'(sum_out), 32'(e.sum));
        chk("runs_out", 32'(runs_out), 32'(e.runs));
        chk("pass", 32'(pass), 32'(e.pass));
        chk("blocks_done", 32'(blocks_done), 32'(e.done));
        chk("blocks_failed", 32'(blocks_failed), 32'(e.failed));
      end
    end
  end

  task automatic start_test(input logic [4:0] thr, input logic c);
    start = 1'b1;
    threshold = thr;
    cont = c;
    @(posedge clk); #1;
    start = 1'b0;
    threshold = ~thr;
  endtask

  task automatic send_beat(input logic [3:0] b);
    int n = 0;
    bits_in = b;
    bits_valid = 1'b1;
    while (!(in_ready && ena) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("beat_timeout", 32'(n), 32'(0));
    @(posedge clk); #1;
    bits_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; ena = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0;
    bits_valid = 1'b0; bits_in = '0; threshold = '0;
    vecs[0] = '{16'hFFFF, 5'd4,  6'h10, 5'd1,  1'b0};
    vecs[1] = '{16'hAAAA, 5'd0,  6'h00, 5'd16, 1'b1};
    vecs[2] = '{16'h0000, 5'd16, 6'h30, 5'd1,  1'b1};
    vecs[3] = '{16'h0000, 5'd15, 6'h30, 5'd1,  1'b0};
    vecs[4] = '{16'h1111, 5'd8,  6'h38, 5'd8,  1'b1};
    vecs[5] = '{16'h1111, 5'd7,  6'h38, 5'd8,  1'b0};
    vecs[6] = '{16'hF0C3, 5'd0,  6'h00, 5'd5,  1'b1};
    vecs[7] = '{16'h8888, 5'd10, 6'h38, 5'd8,  1'b1};
    vecs[8] = '{16'h7FFE, 5'd12, 6'h0C, 5'd3,  1'b1};
    vecs[9] = '{16'hFFFF, 5'd16, 6'h10, 5'd1,  1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_result_valid", 32'(result_valid), 0);
    chk("rst_sum", 32'(sum_out), 0);
    chk("rst_runs", 32'(runs_out), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_done", 32'(blocks_done), 0);
    chk("rst_failed", 32'(blocks_failed), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 10; v++) begin
      sb.push_back('{vecs[v].sum, vecs[v].runs, vecs[v].pass, 16'd1,
                     vecs[v].pass ? 16'd0 : 16'd1});
      start_test(vecs[v].thr, 1'b0);
      for (int b = 0; b < 4; b++) send_beat(vecs[v].beats[b*4 +: 4]);
      chk("latency_rv", 32'(result_valid), 1);
      @(posedge clk); #1;
      chk("rv_pulse", 32'(result_valid), 0);
      chk("idle_after", 32'(busy), 0);
    end

    // continuous: three blocks back to back, one REPORT gap each
    for (int i = 1; i <= 3; i++) sb.push_back('{6'h38, 5'd8, 1'b0, 16'(i), 16'(i)});
    start_test(5'd4, 1'b1);
    bits_in = 4'h1;
    bits_valid = 1'b1;
    for (int c = 0; c < 15; c++) begin
      chk("cont_in_ready", 32'(in_ready), (c % 5 == 4) ? 0 : 1);
      if (c == 14) begin
        stop = 1'b1;
        bits_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    stop = 1'b0;
    chk("cont_busy", 32'(busy), 0);
    chk("cont_done", 32'(blocks_done), 3);
    chk("cont_failed", 32'(blocks_failed), 3);

    // stop after two beats, then a stalled block
    start_test(5'd16, 1'b0);
    chk("start_clr_done", 32'(blocks_done), 0);
    chk("start_clr_failed", 32'(blocks_failed), 0);
    send_beat(4'h0);
    send_beat(4'h0);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 0);
    chk("stop_done", 32'(blocks_done), 0);
    sb.push_back('{6'h00, 5'd3, 1'b1, 16'd1, 16'd0});
    start_test(5'd16, 1'b0);
    send_beat(4'hF);
    ena = 1'b0;
    bits_in = 4'hF;
    bits_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("stall_busy", 32'(busy), 1);
    chk("stall_no_rv", 32'(result_valid), 0);
    ena = 1'b1;
    send_beat(4'h0);
    send_beat(4'h0);
    send_beat(4'hF);
    chk("stall_latency_rv", 32'(result_valid), 1);
    @(posedge clk); #1;

    // asynchronous reset between edges
    start_test(5'd3, 1'b0);
    send_beat(4'h5);
    send_beat(4'h5);
    #2;
    rst_n = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    chk("arst_runs", 32'(runs_out), 0);
    chk("arst_pass", 32'(pass), 0);
    chk("arst_done", 32'(blocks_done), 0);
    @(negedge clk);
    rst_n = 1'b0;
    bits_in = 4'h5;
    bits_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bits_valid = 1'b0;
    chk("arst_stays_idle", 32'(busy), 0);

    // saturation on the narrow instance, then start/stop priority
    for (int i = 1; i <= 5; i++) sb.push_back('{6'h10, 5'd1, 1'b0, 16'(i), 16'(i)});
    start_test(5'd0, 1'b1);
    bits_in = 4'hF;
    bits_valid = 1'b1;
    for (int c = 0; c < 25; c++) begin
      if (c == 24) begin
        stop = 1'b1;
        bits_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    stop = 1'b0;
    chk("sat_wide_done", 32'(blocks_done), 5);
    chk("sat_done", 32'(s_done), 3);
    chk("sat_failed", 32'(s_failed), 3);
    chk("sat_busy", 32'(busy), 0);
    start = 1'b1;
    stop = 1'b1;
    threshold = 5'd16;
    @(posedge clk); #1;
    start = 1'b0;
    stop = 1'b0;
    chk("prio_busy", 32'(busy), 0);
    chk("prio_tally_kept", 32'(blocks_done), 5);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/monobit_block_engine.md
# monobit_block_engine

Parametrised successor to the single-stream monobit tester. It consumes a multi-lane bit stream in fixed-length blocks and computes, per block, the NIST monobit sum S = ones − zeros and the runs count. It flags pass/fail against a programmable |S| threshold and keeps saturating block and failure tallies. It sits behind the TRNG/bitstream capture path inside the top-level user project and feeds the status/readout mux.

## Interface

- `LANES`, default 4: bits accepted per beat; lane 0 is the earliest bit in time.
- `LOG2_BLOCK`, default 10: block length BLOCK = 2^LOG2_BLOCK bits. BLOCK must be a multiple of LANES and ≥ 2·LANES.
- `CNT_W`, default 16: width of the block and failure tallies.

Ports:

- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: **asynchronous, active-high reset.** 1 = reset, despite the legacy `_n` name.
- `ena`, in, 1: global enable. When low, no beat is accepted and no state advances, except for reset.
- `start`, in, 1: pulse; starts a test and samples `threshold` and `cont`.
- `stop`, in, 1: pulse; aborts the run and discards any partial block.
- `cont`, in, 1: 1 = continuous, back-to-back blocks; 0 = single block.
- `threshold`, in, LOG2_BLOCK+1: maximum passing |S|.
- `bits_in`, in, LANES: data beat.
- `bits_valid`, in, 1: beat is present.
- `in_ready`, out, 1: high while in ACCUM; a beat is accepted when `bits_valid & in_ready & ena`.
- `result_valid`, out, 1: one-cycle pulse when a block completes.
- `sum_out`, out, LOG2_BLOCK+2: signed S = 2·ones − BLOCK.
- `runs_out`, out, LOG2_BLOCK+1: number of runs in the block, equal to transitions + 1.
- `pass`, out, 1: |S| ≤ captured threshold.
- `busy`, out, 1: state ≠ IDLE.
- `blocks_done`, out, CNT_W: saturating count of completed blocks.
- `blocks_failed`, out, CNT_W: saturating count of failed blocks.

## Operation

States: IDLE, ACCUM, REPORT.

- **IDLE**
  - `start & ena & !stop` → ACCUM.
  - On that transition: capture `threshold` and `cont`, clear `blocks_done` and `blocks_failed`, clear the ones and runs accumulators and the beat counter.
  - `stop` has priority over `start` in the same cycle; the block stays in IDLE.
- **ACCUM**
  - Per accepted beat: ones += popcount(`bits_in`).
  - Transitions are counted between adjacent lanes, plus between the last lane of the previous beat and lane 0 of the current beat.
  - There is no cross-beat compare on the first beat of a block, and no carry between blocks.
  - Beat counter counts 0 … BLOCK/LANES−1. Accepting the final beat → REPORT.
  - `start` is ignored. `stop` → IDLE, with the partial block discarded.
- **REPORT**, one cycle
  - Registered outputs are already valid. `in_ready` = 0.
  - Next state is ACCUM if the captured `cont` = 1 (accumulators cleared), otherwise IDLE.
  - `stop` → IDLE. The result being reported in this cycle still counts.
- **Arithmetic:** ones is LOG2_BLOCK+1 bits wide. S is computed in LOG2_BLOCK+2-bit two's complement. |S| is LOG2_BLOCK+1 bits; |−BLOCK| = BLOCK is representable.
- **Tallies:** increment at most once per block and saturate at all-ones. `blocks_failed` increments only when `pass` = 0.
- **Reset values:** state IDLE and every output 0, including `sum_out`, `runs_out` and `pass`. Captured threshold and `cont` are also reset to 0.
- **Reset mid-run:** asynchronous return to IDLE. No `result_valid` pulse is produced.

## Timing

- Result latency: `result_valid` is high in the cycle after the final beat is accepted.
- `sum_out`, `runs_out` and `pass` update in that same cycle and hold until the next result.
- `blocks_done` and `blocks_failed` update in the same cycle as `result_valid`.
- Continuous mode: exactly one non-ready cycle (REPORT) between blocks. Peak throughput is BLOCK/LANES beats per BLOCK/LANES + 1 cycles.
- `ena` = 0 freezes the state, counters and accumulators. A `result_valid` that is already high completes its single cycle.
- `threshold` changes after `start` have no effect until the next `start`.

## Test plan

Settings: LANES = 4, LOG2_BLOCK = 4 (16-bit blocks, 4 beats), CNT_W = 16 unless stated.

1. **All ones:** `start` with `threshold` = 4, then 4 beats of 4'hF → `result_valid` 1 cycle after beat 4. Expect `sum_out` = +16, `runs_out` = 1, `pass` = 0, `blocks_done` = 1, `blocks_failed` = 1, return to IDLE.
2. **Alternating:** 4 beats of 4'hA (lanes 0,1,0,1) with `threshold` = 0 → `sum_out` = 0, `runs_out` = 16, `pass` = 1, `blocks_failed` = 0.
3. **Continuous mode:** `cont` = 1, 3 blocks of 4'h1 with `bits_valid` held high → `in_ready` drops for exactly 1 cycle between blocks. Each block gives `sum_out` = −8 and `runs_out` = 8. Final `blocks_done` = 3.
4. **Stall and stop:** beats presented while `ena` = 0 are not counted. Assert `stop` after 2 accepted beats → IDLE with no `result_valid` and tallies unchanged. A following `start` clears the tallies and a full block reports correctly.
5. **Async reset:** assert `rst_n` = 1 mid-ACCUM, between clock edges → `busy`, `in_ready` and all outputs go to 0 immediately. No `result_valid` after release.
6. **Saturation and priority:** with CNT_W = 2, 5 continuous failing blocks → `blocks_done` = 3 and `blocks_failed` = 3. Separately, `start` and `stop` in the same cycle in IDLE → the block stays in IDLE.
